// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// PC step, default reset PC and the prefetch queue entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch unit, the instruction ROM, execute (redirect/halt)
// and decode. Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both 1; out_valid never depends on out_ready.
interface inst_fetch_if;
  import fetch_pkg::*;

  logic         imem_ce;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         halt;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_inst;
  logic [31:0]  out_pc;
  logic         fetch_halted;
  fetch_state_e dbg_state;

  modport master (
    output imem_ce, imem_addr, out_valid, out_inst, out_pc, fetch_halted, dbg_state,
    input  imem_data, redirect_valid, redirect_pc, halt, out_ready
  );

  modport slave (
    input  imem_ce, imem_addr, out_valid, out_inst, out_pc, fetch_halted, dbg_state,
    output imem_data, redirect_valid, redirect_pc, halt, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries with synchronous flush. Head reads zero
// when empty; storage is not cleared, only the pointers and count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output logic          o_valid,
  output fetch_entry_t  o_head
);

  fetch_entry_t  r_mem [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, fetch FSM and ROM port; fetched words go through
// fetch_queue to decode. Optional FETCH_ALIGN_CHECK_EN adds misaligned-redirect trapping.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic         fetch_err
`endif
);

  localparam int            CW      = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_redirect_target;
  logic          w_misaligned;
  logic          w_pop;
  logic          w_push;
  logic          w_push_ok;
  logic          w_q_valid;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fetch_err;

  assign w_misaligned      = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign w_redirect_target = bus.redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_fetch_err <= 1'b0;
    else if (w_misaligned) r_fetch_err <= 1'b1;
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_misaligned      = 1'b0;
  assign w_redirect_target = bus.redirect_pc & ~32'h3;
`endif

  assign w_pop     = w_q_valid && bus.out_ready;
  assign w_push_ok = (w_count < DEPTH_C) || w_pop;
  assign w_push    = (r_state == ST_FETCH) && w_push_ok && !bus.redirect_valid && !bus.halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   w_state_nxt = ST_FETCH;
      ST_FETCH:  if (bus.halt) w_state_nxt = ST_HALTED;
      ST_HALTED: if (bus.redirect_valid && !bus.halt) w_state_nxt = ST_FETCH;
      default:   w_state_nxt = ST_IDLE;
    endcase
    // A misaligned target must never be fetched, so it parks the unit.
    if (w_misaligned) w_state_nxt = ST_HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_pc <= RESET_PC;
    else if (bus.redirect_valid) r_pc <= w_redirect_target;
    else if (w_push)             r_pc <= r_pc + PC_STEP;
  end

  assign w_push_data = '{pc: r_pc, inst: bus.imem_data};

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (bus.redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_valid     (w_q_valid),
    .o_head      (w_head)
  );

  assign bus.imem_ce      = w_push;
  assign bus.imem_addr    = r_pc;
  assign bus.out_valid    = w_q_valid;
  assign bus.out_inst     = w_head.inst;
  assign bus.out_pc       = w_head.pc;
  assign bus.fetch_halted = (r_state == ST_HALTED);
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot stream, backpressure/full throughput,
// redirect flush, halt, async reset and misaligned redirect handling.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_q[$];

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err;
`endif

  inst_fetch_if bus_if ();

  inst_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_err (fetch_err)
`endif
  );

  always #5 clk = ~clk;

  // Boot image ROM; unlisted words carry an address-derived pattern.
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    case (w)
      30'h00:  return 32'h0000f025;
      30'h01:  return 32'h241d1000;
      30'h02:  return 32'h8f990048;
      30'h08:  return 32'h27bdffe0;
      30'h22:  return 32'h27bdffe0;
      default: return 32'hA500_0000 | {16'h0000, w[13:0], 2'b00};
    endcase
  endfunction

  assign bus_if.imem_data = rom(bus_if.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    bus_if.halt           = 1'b0;
    bus_if.out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, bus_if.out_valid}, 32'h1);
    chk({tag, "_pc"}, bus_if.out_pc, pc);
    chk({tag, "_inst"}, bus_if.out_inst, rom(pc));
  endtask

  initial begin
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    bus_if.halt           = 1'b0;
    bus_if.out_ready      = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    chk("rst_addr", bus_if.imem_addr, 32'h0);
    chk("rst_valid", {31'h0, bus_if.out_valid}, 32'h0);
    chk("rst_inst", bus_if.out_inst, 32'h0);
    chk("rst_pc", bus_if.out_pc, 32'h0);
    chk("rst_halted", {31'h0, bus_if.fetch_halted}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_err", {31'h0, fetch_err}, 32'h0);
`endif

    // 1: boot stream with decode always ready
    do_reset();
    bus_if.out_ready = 1'b1;
    #1;
    chk("t1_idle_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    tick();
    chk("t1_ce", {31'h0, bus_if.imem_ce}, 32'h1);
    chk("t1_addr", bus_if.imem_addr, 32'h0);
    chk("t1_valid0", {31'h0, bus_if.out_valid}, 32'h0);
    tick();
    chk("t1_inst0", bus_if.out_inst, 32'h0000f025);
    chk_head("t1_h0", 32'h0);
    tick();
    chk("t1_inst1", bus_if.out_inst, 32'h241d1000);
    chk_head("t1_h1", 32'h4);
    tick();
    chk("t1_inst2", bus_if.out_inst, 32'h8f990048);
    chk_head("t1_h2", 32'h8);
    tick();
    chk_head("t1_h3", 32'hC);

    // 2 and 5: backpressure fills 4 entries, then full-queue streaming
    do_reset();
    tick();
    repeat (4) tick();
    chk("t2_full_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    chk("t2_full_addr", bus_if.imem_addr, 32'h10);
    chk_head("t2_full_head", 32'h0);
    tick();
    chk("t2_hold_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    chk("t2_hold_addr", bus_if.imem_addr, 32'h10);
    for (int i = 0; i < 20; i++) exp_q.push_back(32'(i * 4));
    bus_if.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk_head("t5_stream", e);
      chk("t5_ce", {31'h0, bus_if.imem_ce}, 32'h1);
      chk("t5_addr", bus_if.imem_addr, e + 32'h10);
      tick();
    end

    // 3: redirect with 3 entries queued
    do_reset();
    tick();
    repeat (3) tick();
    chk_head("t3_pre", 32'h0);
    chk("t3_pre_addr", bus_if.imem_addr, 32'hC);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h88;
    #1;
    chk("t3_redir_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    tick();
    bus_if.redirect_valid = 1'b0;
    bus_if.out_ready      = 1'b1;
    #1;
    chk("t3_flush_valid", {31'h0, bus_if.out_valid}, 32'h0);
    chk("t3_flush_inst", bus_if.out_inst, 32'h0);
    chk("t3_flush_pc", bus_if.out_pc, 32'h0);
    chk("t3_flush_addr", bus_if.imem_addr, 32'h88);
    chk("t3_flush_ce", {31'h0, bus_if.imem_ce}, 32'h1);
    tick();
    chk("t3_target_inst", bus_if.out_inst, 32'h27bdffe0);
    chk_head("t3_target", 32'h88);
    tick();
    chk_head("t3_next", 32'h8C);

    // 4: halt at pc 0x10, drain, resume via redirect, then halt+redirect together
    do_reset();
    tick();
    repeat (4) tick();
    chk("t4_pc10", bus_if.imem_addr, 32'h10);
    bus_if.halt = 1'b1;
    #1;
    chk("t4_halt_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    tick();
    bus_if.halt      = 1'b0;
    bus_if.out_ready = 1'b1;
    #1;
    chk("t4_halted", {31'h0, bus_if.fetch_halted}, 32'h1);
    chk("t4_halted_addr", bus_if.imem_addr, 32'h10);
    for (int i = 0; i < 4; i++) begin
      chk_head("t4_drain", 32'(i * 4));
      chk("t4_drain_ce", {31'h0, bus_if.imem_ce}, 32'h0);
      tick();
    end
    chk("t4_empty", {31'h0, bus_if.out_valid}, 32'h0);
    chk("t4_empty_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    chk("t4_still_halted", {31'h0, bus_if.fetch_halted}, 32'h1);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h20;
    #1;
    chk("t4_redir_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    tick();
    bus_if.redirect_valid = 1'b0;
    #1;
    chk("t4_resumed", {31'h0, bus_if.fetch_halted}, 32'h0);
    chk("t4_resume_ce", {31'h0, bus_if.imem_ce}, 32'h1);
    chk("t4_resume_addr", bus_if.imem_addr, 32'h20);
    tick();
    chk("t4_resume_inst", bus_if.out_inst, 32'h27bdffe0);
    chk_head("t4_resume", 32'h20);
    bus_if.halt           = 1'b1;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h40;
    #1;
    chk("t4_both_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    tick();
    bus_if.halt           = 1'b0;
    bus_if.redirect_valid = 1'b0;
    #1;
    chk("t4_both_halted", {31'h0, bus_if.fetch_halted}, 32'h1);
    chk("t4_both_addr", bus_if.imem_addr, 32'h40);
    chk("t4_both_valid", {31'h0, bus_if.out_valid}, 32'h0);
    chk("t4_both_ce2", {31'h0, bus_if.imem_ce}, 32'h0);
    tick();
    chk("t4_both_hold", {31'h0, bus_if.fetch_halted}, 32'h1);
    chk("t4_both_hold_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    chk("t4_both_hold_addr", bus_if.imem_addr, 32'h40);

    // 6: asynchronous reset mid-stream
    do_reset();
    bus_if.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_pre_valid", {31'h0, bus_if.out_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'h0, bus_if.out_valid}, 32'h0);
    chk("t6_async_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    chk("t6_async_addr", bus_if.imem_addr, 32'h0);
    chk("t6_async_pc", bus_if.out_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_addr", bus_if.imem_addr, 32'h0);
    chk("t6_rel_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    tick();
    chk("t6_run_ce", {31'h0, bus_if.imem_ce}, 32'h1);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h22;
    #1;
    tick();
    bus_if.redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_err", {31'h0, fetch_err}, 32'h1);
    chk("t6_err_halted", {31'h0, bus_if.fetch_halted}, 32'h1);
    chk("t6_err_ce", {31'h0, bus_if.imem_ce}, 32'h0);
    chk("t6_err_valid", {31'h0, bus_if.out_valid}, 32'h0);
    tick();
    chk("t6_err_sticky", {31'h0, fetch_err}, 32'h1);
    chk("t6_err_ce2", {31'h0, bus_if.imem_ce}, 32'h0);
`else
    chk("t6_mask_addr", bus_if.imem_addr, 32'h20);
    chk("t6_mask_ce", {31'h0, bus_if.imem_ce}, 32'h1);
    chk("t6_mask_valid", {31'h0, bus_if.out_valid}, 32'h0);
    chk("t6_mask_halted", {31'h0, bus_if.fetch_halted}, 32'h0);
    tick();
    chk("t6_mask_inst", bus_if.out_inst, 32'h27bdffe0);
    chk_head("t6_mask_head", 32'h20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
